// File: rtl/wasm_mem_bulk_ctrl.sv
// wasm_mem_bulk_ctrl: byte-serial engine for WebAssembly memory.fill / memory.copy.
// Ports: clk_i/rst_ni clock and async active-low reset; cmd_* command handshake
// (op 0=fill 1=copy, dst/src/len/val); current_pages_i live memory size;
// mem_rd_*/mem_wr_* byte accesses to linear memory with mem_trap_i fault report;
// busy_o, done_o pulse and done_trap_o result.
package wasm_pkg;
    typedef enum logic [3:0] {
        MEM_LOAD_I32, MEM_LOAD_I64, MEM_LOAD_I8_S, MEM_LOAD_I8_U, MEM_LOAD_I16_S,
        MEM_LOAD_I16_U, MEM_STORE_I32, MEM_STORE_I64, MEM_STORE_I8, MEM_STORE_I16
    } mem_op_t;
    typedef enum logic [2:0] {
        TRAP_NONE, TRAP_OUT_OF_BOUNDS, TRAP_UNALIGNED, TRAP_UNREACHABLE, TRAP_DIV_ZERO
    } trap_t;
endpackage

module wasm_mem_bulk_ctrl
    import wasm_pkg::*;
#(
    parameter int unsigned PAGE_BYTES = 65536
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_op_i,
    input  logic [31:0] cmd_dst_i,
    input  logic [31:0] cmd_src_i,
    input  logic [31:0] cmd_len_i,
    input  logic [7:0]  cmd_val_i,
    input  logic [31:0] current_pages_i,
    output logic        mem_rd_en_o,
    output logic [31:0] mem_rd_addr_o,
    output mem_op_t     mem_rd_op_o,
    input  logic [63:0] mem_rd_data_i,
    output logic        mem_wr_en_o,
    output logic [31:0] mem_wr_addr_o,
    output mem_op_t     mem_wr_op_o,
    output logic [63:0] mem_wr_data_o,
    input  trap_t       mem_trap_i,
    output logic        busy_o,
    output logic        done_o,
    output trap_t       done_trap_o
);
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_FILL, S_COPY_FWD, S_COPY_BWD, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        op_q, op_d;
    logic [31:0] dst_q, dst_d, src_q, src_d, len_q, len_d, i_q, i_d;
    logic [7:0]  val_q, val_d;
    trap_t       trap_q, trap_d;

    // Limit and end addresses are formed wide so neither the page product nor
    // dst+len can wrap; only the comparison result matters.
    logic [63:0] limit, end_dst, end_src;
    logic        oob, xfer, last;

    assign limit   = 64'(current_pages_i) * 64'(PAGE_BYTES);
    assign end_dst = 64'(dst_q) + 64'(len_q);
    assign end_src = 64'(src_q) + 64'(len_q);
    assign oob     = (end_dst > limit) || (op_q && end_src > limit);
    assign xfer    = (state_q == S_FILL) || (state_q == S_COPY_FWD) || (state_q == S_COPY_BWD);
    assign last    = (state_q == S_COPY_BWD) ? (i_q == 32'd0) : (i_q == len_q - 32'd1);

    assign mem_rd_op_o = MEM_LOAD_I8_U;
    assign mem_wr_op_o = MEM_STORE_I8;
    assign cmd_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign done_trap_o = (state_q == S_DONE) ? trap_q : TRAP_NONE;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            op_q    <= 1'b0;
            dst_q   <= '0;
            src_q   <= '0;
            len_q   <= '0;
            val_q   <= '0;
            i_q     <= '0;
            trap_q  <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            len_q   <= len_d;
            val_q   <= val_d;
            i_q     <= i_d;
            trap_q  <= trap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        dst_d   = dst_q;
        src_d   = src_q;
        len_d   = len_q;
        val_d   = val_q;
        i_d     = i_q;
        trap_d  = trap_q;
        case (state_q)
            S_IDLE: if (cmd_valid_i) begin
                op_d    = cmd_op_i;
                dst_d   = cmd_dst_i;
                src_d   = cmd_src_i;
                len_d   = cmd_len_i;
                val_d   = cmd_val_i;
                trap_d  = TRAP_NONE;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                trap_d  = oob ? TRAP_OUT_OF_BOUNDS : TRAP_NONE;
                i_d     = (op_q && dst_q > src_q) ? len_q - 32'd1 : 32'd0;
                state_d = (oob || len_q == 32'd0) ? S_DONE :
                          !op_q                   ? S_FILL :
                          (dst_q <= src_q)        ? S_COPY_FWD : S_COPY_BWD;
            end
            S_FILL, S_COPY_FWD, S_COPY_BWD: begin
                // A memory fault ends the command on the faulting byte.
                trap_d  = mem_trap_i;
                state_d = (mem_trap_i != TRAP_NONE || last) ? S_DONE : state_q;
                i_d     = (state_q == S_COPY_BWD) ? i_q - 32'd1 : i_q + 32'd1;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Access outputs derive from state only, so an async reset drops them at once.
    always_comb begin
        mem_rd_en_o   = 1'b0;
        mem_rd_addr_o = '0;
        mem_wr_en_o   = 1'b0;
        mem_wr_addr_o = '0;
        mem_wr_data_o = '0;
        if (xfer) begin
            mem_wr_en_o   = 1'b1;
            mem_wr_addr_o = dst_q + i_q;
            mem_rd_en_o   = (state_q != S_FILL);
            mem_rd_addr_o = (state_q != S_FILL) ? src_q + i_q : 32'd0;
            mem_wr_data_o = {56'b0, (state_q == S_FILL) ? val_q : mem_rd_data_i[7:0]};
        end
    end
endmodule

// File: tb/tb_wasm_mem_bulk_ctrl.sv
// tb_wasm_mem_bulk_ctrl: vector table, directed corner sequences and random commands vs a memmove model.
module tb_wasm_mem_bulk_ctrl;
    import wasm_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_op = 1'b0;
    logic [31:0] cmd_dst = '0, cmd_src = '0, cmd_len = '0, pages = 32'd1;
    logic [7:0]  cmd_val = '0;
    logic        cmd_ready, rd_en, wr_en, busy, done;
    logic [31:0] rd_addr, wr_addr;
    logic [63:0] rd_data, wr_data;
    mem_op_t     rd_op, wr_op;
    trap_t       mem_trap, done_trap;

    logic        trap_arm = 1'b0;
    logic [31:0] trap_addr = '0;
    logic [7:0]  mem_m [65536];
    logic [7:0]  ref_m [65536];

    int n_tests = 0, n_fail = 0;
    int cyc = 0, wr_cnt = 0, done_seen = 0, gap = 0, last_wr = 0, done_cyc = 0;
    logic [31:0] first_wr = '0;
    trap_t       got_trap = TRAP_NONE;
    logic        ready_at_done = 1'b0;

    wasm_mem_bulk_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_dst_i(cmd_dst), .cmd_src_i(cmd_src), .cmd_len_i(cmd_len),
        .cmd_val_i(cmd_val), .current_pages_i(pages),
        .mem_rd_en_o(rd_en), .mem_rd_addr_o(rd_addr), .mem_rd_op_o(rd_op), .mem_rd_data_i(rd_data),
        .mem_wr_en_o(wr_en), .mem_wr_addr_o(wr_addr), .mem_wr_op_o(wr_op), .mem_wr_data_o(wr_data),
        .mem_trap_i(mem_trap), .busy_o(busy), .done_o(done), .done_trap_o(done_trap)
    );

    always #5 clk = ~clk;

    assign rd_data  = (rd_en && rd_addr < 32'h10000) ? {56'b0, mem_m[rd_addr[15:0]]} : 64'b0;
    assign mem_trap = (trap_arm && wr_en && wr_addr == trap_addr) ? TRAP_UNALIGNED : TRAP_NONE;

    always @(posedge clk)
        if (wr_en && mem_trap == TRAP_NONE && wr_addr < 32'h10000) mem_m[wr_addr[15:0]] <= wr_data[7:0];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (wr_en) begin
            if (wr_cnt == 0) first_wr <= wr_addr;
            else if (cyc != last_wr + 1) gap <= gap + 1;
            last_wr <= cyc;
            wr_cnt  <= wr_cnt + 1;
        end
        if (done) begin
            done_seen     <= done_seen + 1;
            got_trap      <= done_trap;
            done_cyc      <= cyc;
            ready_at_done <= cmd_ready;
        end
    end

    typedef struct {
        logic        op;
        logic [31:0] dst, src, len;
        logic [7:0]  val;
        logic [31:0] pg;
        logic        reinit;
        trap_t       exp_trap;
        int          exp_wr;
        logic [31:0] exp_first;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: bounds from 64-bit arithmetic, effect as a memmove/memset on an array snapshot.
    function automatic trap_t exp_trap_of(logic op, logic [31:0] dst, src, len, pg);
        longint unsigned lim = longint'(pg) * 65536;
        if (longint'(dst) + longint'(len) > lim) return TRAP_OUT_OF_BOUNDS;
        if (op && longint'(src) + longint'(len) > lim) return TRAP_OUT_OF_BOUNDS;
        return TRAP_NONE;
    endfunction

    task automatic model_mem(input logic op, input logic [31:0] dst, src, len, input logic [7:0] val, input int upto);
        logic [7:0] tmp[$];
        for (int k = 0; k < upto; k++) tmp.push_back(op ? ref_m[16'(src + k)] : val);
        for (int k = 0; k < upto; k++) ref_m[16'(dst + k)] = tmp[k];
    endtask

    task automatic chk_mem(input string name);
        int bad = 0;
        for (int k = 0; k < 65536; k++) if (mem_m[k] !== ref_m[k]) bad++;
        chk(name, 64'(bad), 64'd0);
    endtask

    task automatic issue(input logic op, input logic [31:0] dst, src, len, input logic [7:0] val);
        int k = 0;
        @(negedge clk);
        wr_cnt = 0; done_seen = 0; gap = 0;
        cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_len = len; cmd_val = val; cmd_valid = 1'b1;
        while (!cmd_ready && k < 50) begin @(negedge clk); k++; end
        if (!cmd_ready) chk("accept_timeout", 64'(cmd_ready), 64'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        do begin @(negedge clk); #1; k++; end while (done_seen == 0 && k < 5000);
        if (done_seen == 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_one(input string name, input logic op, input logic [31:0] dst, src, len,
                           input logic [7:0] val, input logic [31:0] pg, input trap_t et,
                           input int ew, input logic [31:0] ef);
        pages  = pg;
        ref_m  = mem_m;
        if (et == TRAP_NONE) model_mem(op, dst, src, len, val, int'(len));
        issue(op, dst, src, len, val);
        wait_done();
        chk({name, "_trap"}, 64'(got_trap), 64'(et));
        chk({name, "_writes"}, 64'(wr_cnt), 64'(ew));
        chk({name, "_done_once"}, 64'(done_seen), 64'd1);
        chk({name, "_ready_in_done"}, 64'(ready_at_done), 64'd0);
        if (ew > 0) begin
            chk({name, "_first_addr"}, 64'(first_wr), 64'(ef));
            chk({name, "_timing"}, 64'(gap == 0 && done_cyc == last_wr + 1), 64'd1);
        end
        repeat (2) @(negedge clk);
        chk_mem({name, "_mem"});
    endtask

    initial begin
        for (int k = 0; k < 65536; k++) mem_m[k] = 8'(k * 7 + 3);
        vt[0] = '{1'b0, 32'h10, 32'h0, 32'd4, 8'hAB, 32'd1, 1'b0, TRAP_NONE, 4, 32'h10};
        vt[1] = '{1'b1, 32'd2, 32'd0, 32'd6, 8'h00, 32'd1, 1'b1, TRAP_NONE, 6, 32'd7};
        vt[2] = '{1'b1, 32'd0, 32'd2, 32'd6, 8'h00, 32'd1, 1'b1, TRAP_NONE, 6, 32'd0};
        vt[3] = '{1'b0, 32'hFFFF, 32'h0, 32'd2, 8'h55, 32'd1, 1'b0, TRAP_OUT_OF_BOUNDS, 0, 32'd0};
        vt[4] = '{1'b1, 32'h0, 32'hFFFFFFFF, 32'd2, 8'h00, 32'd1, 1'b0, TRAP_OUT_OF_BOUNDS, 0, 32'd0};
        vt[5] = '{1'b0, 32'h10000, 32'h0, 32'd0, 8'h77, 32'd1, 1'b0, TRAP_NONE, 0, 32'd0};
        vt[6] = '{1'b0, 32'h0, 32'h0, 32'd0, 8'h77, 32'd0, 1'b0, TRAP_NONE, 0, 32'd0};
        vt[7] = '{1'b0, 32'hFFFE, 32'h0, 32'd2, 8'hC3, 32'd1, 1'b0, TRAP_NONE, 2, 32'hFFFE};
        vt[8] = '{1'b0, 32'h0, 32'h0, 32'd1, 8'h01, 32'd0, 1'b0, TRAP_OUT_OF_BOUNDS, 0, 32'd0};

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_done_trap", 64'(done_trap), 64'(TRAP_NONE));
        chk("rst_rd_en", 64'(rd_en), 64'd0);
        chk("rst_addrs_data", {rd_addr, wr_addr} | wr_data, 64'd0);
        chk("rd_op_const", 64'(rd_op), 64'(MEM_LOAD_I8_U));
        chk("wr_op_const", 64'(wr_op), 64'(MEM_STORE_I8));

        for (int v = 0; v < 9; v++) begin
            if (vt[v].reinit) for (int k = 0; k < 8; k++) mem_m[k] = 8'(k);
            run_one($sformatf("vec%0d", v), vt[v].op, vt[v].dst, vt[v].src, vt[v].len, vt[v].val,
                    vt[v].pg, vt[v].exp_trap, vt[v].exp_wr, vt[v].exp_first);
        end
        chk("fill_readback", {mem_m[16'h10], mem_m[16'h11], mem_m[16'h12], mem_m[16'h13]}, 64'hABABABAB);

        // Fault on the fourth byte of a forward copy: three bytes land, then stop.
        pages = 32'd1; trap_arm = 1'b1; trap_addr = 32'h503;
        ref_m = mem_m;
        model_mem(1'b1, 32'h500, 32'h600, 32'd10, 8'h00, 3);
        issue(1'b1, 32'h500, 32'h600, 32'd10, 8'h00);
        wait_done();
        chk("memtrap_trap", 64'(got_trap), 64'(TRAP_UNALIGNED));
        chk("memtrap_writes", 64'(wr_cnt), 64'd4);
        repeat (2) @(negedge clk);
        chk_mem("memtrap_mem");
        trap_arm = 1'b0;

        // Commands offered while busy are dropped; page count shrinking mid-run is ignored.
        ref_m = mem_m;
        model_mem(1'b0, 32'h100, 32'h0, 32'd8, 8'h11, 8);
        issue(1'b0, 32'h100, 32'h0, 32'd8, 8'h11);
        cmd_valid = 1'b1; cmd_dst = 32'h200; cmd_len = 32'd4; cmd_val = 8'h22;
        repeat (4) @(negedge clk);
        pages = 32'd0;
        cmd_valid = 1'b0;
        wait_done();
        chk("busy_ignore_trap", 64'(got_trap), 64'(TRAP_NONE));
        chk("busy_ignore_writes", 64'(wr_cnt), 64'd8);
        repeat (2) @(negedge clk);
        chk_mem("busy_ignore_mem");
        pages = 32'd1;

        // Async reset in the middle of a 100-byte copy.
        issue(1'b1, 32'h1000, 32'h2000, 32'd100, 8'h00);
        for (int k = 0; k < 500 && wr_cnt < 50; k++) begin @(negedge clk); #1; end
        chk("midrst_reached50", 64'(wr_cnt), 64'd50);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_drop", 64'(wr_en), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        repeat (5) @(negedge clk);
        #1;
        chk("midrst_no_done", 64'(done_seen), 64'd0);
        chk("midrst_no_more_wr", 64'(wr_cnt), 64'd50);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready", 64'(cmd_ready), 64'd1);
        run_one("post_rst_fill", 1'b0, 32'h3000, 32'h0, 32'd5, 8'h5A, 32'd1, TRAP_NONE, 5, 32'h3000);

        for (int r = 0; r < 30; r++) begin
            logic        op  = 1'($urandom_range(0, 1));
            logic [31:0] len = $urandom_range(0, 40);
            logic [31:0] dst = $urandom_range(0, 65535);
            logic [31:0] src = $urandom_range(0, 7) == 0 ? dst + $urandom_range(0, 8) : $urandom_range(0, 65535);
            logic [31:0] pg  = $urandom_range(0, 9) == 0 ? 32'd0 : 32'd1;
            trap_t       et;
            if ($urandom_range(0, 9) == 0) src = 32'hFFFFFFF0 + $urandom_range(0, 15);
            if ($urandom_range(0, 4) == 0) dst = 32'h10000 - $urandom_range(0, 40);
            et = exp_trap_of(op, dst, src, len, pg);
            run_one($sformatf("rand%0d", r), op, dst, src, len, 8'($urandom), pg, et,
                    et == TRAP_NONE ? int'(len) : 0, (op && dst > src) ? dst + len - 1 : dst);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wasm_mem_bulk_ctrl.md
WASM_MEM_BULK_CTRL -- requirements
Module: wasm_mem_bulk_ctrl

Interface
REQ-001 SHALL import wasm_pkg and use its mem_op_t and trap_t types.
REQ-002 Parameter: PAGE_BYTES, default 65536, bytes per linear-memory page.
REQ-003 clk  input  1  single clock for all state.
REQ-004 rst_n  input  1  asynchronous reset, active-low.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_op  input  1  0 = memory.fill, 1 = memory.copy.
REQ-008 cmd_dst, cmd_src, cmd_len  input  32 each  destination, source and byte count (cmd_src ignored for fill).
REQ-009 cmd_val  input  8  fill byte.
REQ-010 current_pages  input  32  live page count from linear memory.
REQ-011 mem_rd_en  output  1; mem_rd_addr  output  32; mem_rd_op  output  mem_op_t  (constant MEM_LOAD_I8_U).
REQ-012 mem_rd_data  input  64  combinational read data, same cycle as mem_rd_en.
REQ-013 mem_wr_en  output  1; mem_wr_addr  output  32; mem_wr_op  output  mem_op_t  (constant MEM_STORE_I8); mem_wr_data  output  64.
REQ-014 mem_trap  input  trap_t  trap reported by linear memory for the current access.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle completion pulse; done_trap  output  trap_t  result, valid with done.

Function
REQ-017 States: IDLE, CHECK, FILL, COPY_FWD, COPY_BWD, DONE.
REQ-018 IDLE: on accept, register op, dst, src, len, val; go to CHECK.
REQ-019 CHECK (1 cycle): limit = current_pages * PAGE_BYTES, computed in 33 bits (65536 pages = 2^32 valid).
REQ-020 CHECK: end_dst = {1'b0,dst}+len in 33 bits; for copy also end_src; out of bounds if any end > limit.
REQ-021 Out of bounds: no memory access at all; DONE with TRAP_OUT_OF_BOUNDS.
REQ-022 In bounds and len == 0: DONE with TRAP_NONE, no access (even when dst == limit).
REQ-023 In bounds, fill: go to FILL.
REQ-024 In bounds, copy, dst <= src: go to COPY_FWD.
REQ-025 In bounds, copy, dst > src: go to COPY_BWD.
REQ-026 Throughput is one byte per cycle in FILL/COPY_*.
REQ-027 FILL: mem_wr_en=1, mem_wr_addr=dst+i, mem_wr_data={56'b0,val}; mem_rd_en=0.
REQ-028 COPY_FWD: mem_rd_en=mem_wr_en=1, rd_addr=src+i, wr_addr=dst+i, wr_data={56'b0,mem_rd_data[7:0]}, i counting 0..len-1.
REQ-029 COPY_BWD: same as COPY_FWD with i counting len-1 down to 0, so overlapping regions copy correctly.
REQ-030 Counter i is 32 bits; the last byte exits to DONE with TRAP_NONE on the cycle it is issued.
REQ-031 mem_trap != TRAP_NONE in any transfer cycle: stop immediately, DONE with done_trap = mem_trap; bytes already written stay written.
REQ-032 DONE (1 cycle): done=1, done_trap held; then IDLE; cmd_ready low in DONE.
REQ-033 Outside FILL/COPY_*, mem_rd_en=mem_wr_en=0 and addresses/data are 0.
REQ-034 current_pages changes after CHECK do not affect the running command.
REQ-035 cmd_valid while busy is ignored and not queued.

Reset
REQ-036 rst_n low: state=IDLE; cmd_ready=1 after reset release; busy=0; done=0; done_trap=TRAP_NONE; mem_rd_en=mem_wr_en=0; all addresses, data and registered command fields 0.
REQ-037 Reset mid-transfer aborts at once; no further write is issued; no done pulse.

Verification
REQ-038 pages=1, fill dst=0x10 len=4 val=0xAB -> writes 0x10..0x13 on 4 consecutive cycles; done 1 cycle later, TRAP_NONE; bytes read back 0xAB.
REQ-039 pages=1, mem[0..7]=0..7, copy dst=2 src=0 len=6 -> backward order (addr 7 first); mem[2..7]=0..5.
REQ-040 Same memory, copy dst=0 src=2 len=6 -> forward order; mem[0..5]=2..7.
REQ-041 pages=1, fill dst=0xFFFF len=2 -> no mem_wr_en pulse; done with TRAP_OUT_OF_BOUNDS. Copy dst=0 src=0xFFFFFFFF len=2 (33-bit overflow) -> same response.
REQ-042 pages=1, fill dst=0x10000 len=0 -> done with TRAP_NONE, zero accesses; pages=0, len=0, dst=0 -> TRAP_NONE.
REQ-043 Copy len=100, rst_n low on byte 50 -> mem_wr_en drops asynchronously, no done; after release, cmd_ready=1 and a new fill completes normally.
